// File: rtl/hazard_ctrl.sv
// LEGv8 five-stage hazard unit: load-use stall, taken-branch flush, EX/MEM and
// MEM/WB forwarding selects, and saturating stall/flush event counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        br_taken,
  input  logic        hold,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [4:0]  XZR     = 5'd31;
  localparam logic [4:0]  LINK    = 5'd30;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;

  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_EXM = 2'b10;
  localparam logic [1:0]  FWD_MWB = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       writes;
    logic       load;
  } shadow_t;

  typedef struct packed {
    logic       a_v;
    logic [4:0] a;
    logic       b_v;
    logic [4:0] b;
    logic       d_v;
    logic [4:0] d;
    logic       load;
  } dec_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_STALL,
    ACT_ADV
  } act_e;

  // A register field only counts when it is used and is not XZR.
  function automatic logic live(input logic used, input logic [4:0] r);
    return used && (r != XZR);
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t r;
    r = '0;
    case (instr[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        r.a = instr[9:5];
        r.b = instr[20:16];
        r.d = instr[4:0];
        r.a_v = live(1'b1, r.a);
        r.b_v = live(1'b1, r.b);
        r.d_v = live(1'b1, r.d);
      end
      OP_LSL, OP_LSR: begin
        r.a = instr[9:5];
        r.d = instr[4:0];
        r.a_v = live(1'b1, r.a);
        r.d_v = live(1'b1, r.d);
      end
      OP_LDUR: begin
        r.a = instr[9:5];
        r.d = instr[4:0];
        r.a_v = live(1'b1, r.a);
        r.d_v = live(1'b1, r.d);
        r.load = 1'b1;
      end
      OP_STUR: begin
        r.a = instr[9:5];
        r.b = instr[4:0];
        r.a_v = live(1'b1, r.a);
        r.b_v = live(1'b1, r.b);
      end
      default: begin
        case (instr[31:24])
          OP_CBZ, OP_CBNZ: begin
            r.b = instr[4:0];
            r.b_v = live(1'b1, r.b);
          end
          default: begin
            case (instr[31:26])
              OP_BL: begin
                r.d = LINK;
                r.d_v = 1'b1;
              end
              OP_B:    r = '0;
              default: r = '0;
            endcase
          end
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic hits(input shadow_t e, input logic used, input logic [4:0] r);
    return e.valid && e.writes && used && (e.dest != XZR) && (r == e.dest);
  endfunction

  // The entry now in EX will sit in EX/MEM next cycle; the one in MEM in MEM/WB.
  function automatic logic [1:0] fwd_sel(input shadow_t ex, input shadow_t mem,
                                         input logic used, input logic [4:0] r);
    logic [1:0] s;
    if (hits(ex, used, r)) begin
      s = FWD_EXM;
    end else if (hits(mem, used, r)) begin
      s = FWD_MWB;
    end else begin
      s = FWD_RF;
    end
    return s;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  shadow_t     ex_q, ex_d, mem_q, mem_d;
  logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  dec_t        dec_s;
  logic        load_use_s;
  act_e        act_s;

  assign dec_s = decode(id_instr);
  assign load_use_s = id_valid && ex_q.valid && ex_q.load &&
                      (hits(ex_q, dec_s.a_v, dec_s.a) || hits(ex_q, dec_s.b_v, dec_s.b));

  // Priority: reset, then hold, then taken branch, then load-use stall.
  always_comb begin
    act_s = ACT_ADV;
    if (rst) begin
      act_s = ACT_RESET;
    end else if (hold) begin
      act_s = ACT_HOLD;
    end else if (br_taken) begin
      act_s = ACT_FLUSH;
    end else if (load_use_s) begin
      act_s = ACT_STALL;
    end else begin
      act_s = ACT_ADV;
    end
  end

  // Zero-latency pipeline enables and flush controls.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    case (act_s)
      ACT_RESET: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end
      ACT_HOLD: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      ACT_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end
      ACT_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      ACT_ADV: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
      default: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
    endcase
  end

  // Next shadow entries, forwarding selects and counters.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (act_s)
      ACT_ADV: begin
        mem_d        = ex_q;
        ex_d.valid   = id_valid;
        ex_d.dest    = dec_s.d;
        ex_d.writes  = id_valid && dec_s.d_v;
        ex_d.load    = id_valid && dec_s.load;
        if (id_valid) begin
          fwd_a_d = fwd_sel(ex_q, mem_q, dec_s.a_v, dec_s.a);
          fwd_b_d = fwd_sel(ex_q, mem_q, dec_s.b_v, dec_s.b);
        end else begin
          fwd_a_d = FWD_RF;
          fwd_b_d = FWD_RF;
        end
      end
      ACT_STALL: begin
        mem_d       = ex_q;
        ex_d        = '0;
        fwd_a_d     = FWD_RF;
        fwd_b_d     = FWD_RF;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
      ACT_FLUSH: begin
        ex_d        = '0;
        mem_d       = '0;
        fwd_a_d     = FWD_RF;
        fwd_b_d     = FWD_RF;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
      ACT_HOLD, ACT_RESET: begin
        ex_d  = ex_q;
        mem_d = mem_q;
      end
      default: begin
        ex_d  = ex_q;
        mem_d = mem_q;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed expectations for stalls,
// forwarding, XZR, branch flush, hold, reset and counter saturation.
module tb_hazard_ctrl;

  localparam logic [31:0] LDUR   = 32'hF8400041; // LDUR X1,[X2]
  localparam logic [31:0] ADD    = 32'h8B040023; // ADD X3,X1,X4
  localparam logic [31:0] SUB    = 32'hCB030065; // SUB X5,X3,X3
  localparam logic [31:0] ADDZ   = 32'h8B04003F; // ADD XZR,X1,X4
  localparam logic [31:0] RDZ    = 32'h8B1F03E6; // ADD X6,XZR,XZR
  localparam logic [31:0] LDZ    = 32'hF840005F; // LDUR XZR,[X2]

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        br_taken;
  logic        hold;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .br_taken(br_taken), .hold(hold), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
  task automatic ctl(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [31:0] ins, input logic v, input logic br, input logic hd);
    id_instr = ins;
    id_valid = v;
    br_taken = br;
    hold     = hd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set(32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set(32'd0, 1'b0, 1'b0, 1'b0);
    ctl("rst_ctl", 5'b00111);
    tick();
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 32'd0);
    rst = 1'b0;

    // Load-use: LDUR X1 then ADD reading X1
    set(LDUR, 1'b1, 1'b0, 1'b0);
    ctl("ld_adv", 5'b11000);
    tick();
    set(ADD, 1'b1, 1'b0, 1'b0);
    ctl("lu_stall", 5'b00010);
    tick();
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("lu_bubble_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    ctl("lu_release", 5'b11000);
    tick();
    chk("lu_fwd_memwb", {28'd0, fwd_a, fwd_b}, {28'd0, 4'b0100});

    // EX forwarding: SUB X5,X3,X3 behind ADD X3
    set(SUB, 1'b1, 1'b0, 1'b0);
    ctl("exfwd_nostall", 5'b11000);
    tick();
    chk("exfwd_sel", {28'd0, fwd_a, fwd_b}, {28'd0, 4'b1010});
    set(32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    tick();

    // XZR never matches
    set(ADDZ, 1'b1, 1'b0, 1'b0);
    tick();
    set(RDZ, 1'b1, 1'b0, 1'b0);
    ctl("xzr_nostall", 5'b11000);
    tick();
    chk("xzr_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    set(LDZ, 1'b1, 1'b0, 1'b0);
    tick();
    set(RDZ, 1'b1, 1'b0, 1'b0);
    ctl("xzr_ld_nostall", 5'b11000);
    tick();
    chk("xzr_ld_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("xzr_ld_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);

    // Taken branch beats a simultaneous load-use
    do_reset();
    set(LDUR, 1'b1, 1'b0, 1'b0);
    tick();
    set(ADD, 1'b1, 1'b1, 1'b0);
    ctl("br_vs_stall", 5'b11111);
    tick();
    chk("br_cnts", {stall_cnt, flush_cnt}, {16'd0, 16'd1});
    chk("br_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    set(ADD, 1'b1, 1'b0, 1'b0);
    ctl("post_br_adv", 5'b11000);
    tick();
    chk("post_br_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);

    // Hold during a pending load-use stall; br_taken ignored while held
    do_reset();
    set(LDUR, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set(ADD, 1'b1, (i == 2), 1'b1);
      ctl("hold_ctl", 5'b00000);
      tick();
      chk("hold_cnts", {stall_cnt, flush_cnt}, 32'd0);
    end
    set(ADD, 1'b1, 1'b0, 1'b0);
    ctl("post_hold_stall", 5'b00010);
    tick();
    chk("post_hold_cnt", {16'd0, stall_cnt}, 32'd1);
    ctl("post_hold_adv", 5'b11000);
    tick();
    chk("post_hold_fwd", {28'd0, fwd_a, fwd_b}, {28'd0, 4'b0100});

    // Reset in the middle of a stall discards everything
    set(LDUR, 1'b1, 1'b0, 1'b0);
    tick();
    set(ADD, 1'b1, 1'b0, 1'b0);
    ctl("mid_stall", 5'b00010);
    rst = 1'b1;
    ctl("mid_rst_ctl", 5'b00111);
    tick();
    rst = 1'b0;
    ctl("after_rst_adv", 5'b11000);
    chk("after_rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
    tick();

    // Saturation: preload near the top, then keep stalling
    do_reset();
    force dut.stall_cnt_q = 16'hFFFC;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 6; i++) begin
      set(LDUR, 1'b1, 1'b0, 1'b0);
      tick();
      set(ADD, 1'b1, 1'b0, 1'b0);
      tick();
      if (i == 2) chk("sat_reach", {16'd0, stall_cnt}, 32'h0000FFFF);
    end
    chk("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    do_reset();
    chk("sat_rst", {16'd0, stall_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  pipeline clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 id_instr  input  32  LEGv8 instruction word currently in the ID stage.
REQ-005 id_valid  input  1  id_instr holds a real instruction; 0 means bubble.
REQ-006 br_taken  input  1  branch resolved taken in MEM this cycle; held high by its source while hold=1.
REQ-007 hold  input  1  external freeze (memory wait).
REQ-008 pc_write, ifid_write  output  1 each  PC and IF/ID register enables.
REQ-009 ifid_flush, idex_bubble, exmem_flush  output  1 each  zero the IF/ID, ID/EX and EX/MEM control fields.
REQ-010 fwd_a, fwd_b  output  2 each  ALU operand select for the instruction in EX: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-011 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-012 Decode of id_instr SHALL classify as follows:
- R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 on [31:21]: src_a=[9:5], src_b=[20:16], dest=[4:0].
- LSL 11010011011 and LSR 11010011010: src_a=[9:5], dest=[4:0].
- LDUR 11111000010: src_a=[9:5], dest=[4:0], load.
- STUR 11111000000: src_a=[9:5], src_b=[4:0].
- CBZ 10110100 and CBNZ 10110101 on [31:24]: src_b=[4:0].
- B 000101 on [31:26]: no sources, no destination.
- BL 100101 on [31:26]: dest=30.
- Any other encoding: no sources, no destination.
REQ-013 A source or destination equal to 31 (XZR) SHALL never match, forward or stall.
REQ-014 The block SHALL track two shadow entries {valid, dest, writes, load}: EX (the instruction in ID/EX) and MEM (the instruction in EX/MEM).
REQ-015 On a normal advance, MEM SHALL take EX, and EX SHALL take the decoded ID instruction, qualified by id_valid.
REQ-016 Load-use stall SHALL be detected when: id_valid, EX.valid, EX.load, and EX.dest matches src_a or src_b.
REQ-017 During a load-use stall, for that cycle: pc_write=0, ifid_write=0, idex_bubble=1; EX SHALL be loaded invalid, MEM SHALL take the old EX, and stall_cnt SHALL increment.
REQ-018 Forward selects SHALL be registered and computed per source on each advance:
- 10 if the EX entry writes the source register; otherwise 01 if the MEM entry writes it; otherwise 00.
- The EX match SHALL take priority over the MEM match.
- The selects SHALL be valid in the cycle the instruction occupies EX.
REQ-019 When a stall or flush cycle inserts a bubble into EX, fwd_a and fwd_b SHALL be registered as 00.
REQ-020 When br_taken=1 and hold=0, for that cycle: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; EX and MEM SHALL be loaded invalid; flush_cnt SHALL increment.
REQ-021 br_taken SHALL take priority over a simultaneous load-use stall; no stall SHALL be counted in that cycle.
REQ-022 hold=1 SHALL take priority over everything except rst:
- pc_write=0, ifid_write=0.
- All flush and bubble outputs 0.
- Shadow entries, fwd selects and counters unchanged.
REQ-023 When none of the above applies, outputs SHALL be: pc_write=1, ifid_write=1, all flush and bubble outputs 0.
REQ-024 pc_write, ifid_write, ifid_flush, idex_bubble and exmem_flush SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-025 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.

Reset
REQ-026 While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1.
REQ-027 On a clock edge with rst=1: shadow entries SHALL become invalid, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0.
REQ-028 rst asserted mid-stall or mid-hold SHALL discard all pending state; the first cycle after reset SHALL be a normal advance.

Verification
REQ-029 Load-use: 0xF8400041 (LDUR X1,[X2]) then 0x8B040023 (ADD X3,X1,X4) -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1; when ADD reaches EX, fwd_a=01, fwd_b=00.
REQ-030 EX forwarding: 0x8B040023 then 0xCB030065 (SUB X5,X3,X3) -> no stall; fwd_a=fwd_b=10 when SUB is in EX.
REQ-031 Zero register: ADD writing X31, then an instruction reading X31 -> fwd=00, no stall; LDUR X31 then a read of X31 -> no stall.
REQ-032 Branch vs. stall: br_taken=1 in the same cycle as a load-use condition -> all three flushes=1, pc_write=1, flush_cnt=1, stall_cnt=0; the next instruction sees fwd=00.
REQ-033 Hold: hold=1 for 3 cycles during the load-use stall of REQ-029 -> enables 0, state and counters frozen; after release, exactly one stall cycle occurs.
REQ-034 Saturation: force 65536 stall cycles -> stall_cnt=16'hFFFF and it stays there; rst -> 0.
